mem_read_responder: RTL and testbench

- Multi-cycle, fully pipelined, single-port word memory that serves the cache fill FSM's read stream.
- Accepts one request per cycle and returns read data exactly LATENCY cycles later, with data_valid asserted for one cycle per read.
- Writes complete in the cycle they are issued; there is no response for a write.
- Sits between the cache miss handlers (I-cache and D-cache, after arbitration) and main memory storage.

---
 rtl/mem_rd_if.sv | 20 ++
 rtl/mem_read_responder.sv | 50 +++++
 tb/tb_mem_read_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_rd_if.sv
// mem_rd_if: request/response bundle between a read requester and the memory responder
interface mem_rd_if;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  inflight;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, inflight
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, inflight
    );
endinterface

// File: rtl/mem_read_responder.sv
// mem_read_responder: pipelined single-port word memory returning reads a fixed LATENCY cycles later
module mem_read_responder #(
    parameter int LATENCY    = 4,
    parameter int INDEX_BITS = 15
) (
    input logic     clk,
    input logic     rst,
    mem_rd_if.slave bus
);
    logic [15:0]           mem [2**INDEX_BITS];
    logic [LATENCY-1:0]    sv;
    logic [15:0]           sd [LATENCY];
    logic [3:0]            inflight_q;
    logic [INDEX_BITS-1:0] idx;
    logic                  rd;
    logic                  unused_addr;

    assign idx         = bus.addr[INDEX_BITS:1];
    assign rd          = bus.enable & ~bus.wr;
    assign unused_addr = ^bus.addr;

    // Writes land in storage at the issuing edge; requests during reset are dropped.
    always_ff @(posedge clk)
        if (!rst && bus.enable && bus.wr)
            mem[idx] <= bus.data_in;

    // Read pipeline: sample at accept, shift every cycle, last stage drives the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sv         <= '0;
            inflight_q <= '0;
            for (int i = 0; i < LATENCY; i++)
                sd[i] <= '0;
        end else begin
            sv[0] <= rd;
            if (rd)
                sd[0] <= mem[idx];
            for (int i = 1; i < LATENCY; i++) begin
                sv[i] <= sv[i-1];
                if (sv[i-1])
                    sd[i] <= sd[i-1];
            end
            inflight_q <= inflight_q + 4'(rd) - 4'(sv[LATENCY-1]);
        end
    end

    assign bus.data_out   = sd[LATENCY-1];
    assign bus.data_valid = sv[LATENCY-1];
    assign bus.inflight   = inflight_q;
endmodule

// File: tb/tb_mem_read_responder.sv
// tb_mem_read_responder: table-driven checks of the LATENCY=4 and LATENCY=1 builds
module tb_mem_read_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_rd_if if0 ();
    mem_rd_if if1 ();

    mem_read_responder #(.LATENCY(4), .INDEX_BITS(15)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    mem_read_responder #(.LATENCY(1), .INDEX_BITS(15)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    typedef struct {
        bit          r;
        bit          e;
        bit          w;
        logic [15:0] a;
        logic [15:0] d;
        bit          edv;
        int          edo;
        int          einf;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic add(input bit r, e, w, input logic [15:0] a, d, input bit edv, input int edo, einf);
        vec_t v;
        v = '{r, e, w, a, d, edv, edo, einf};
        tbl.push_back(v);
    endtask

    task automatic wr_(input logic [15:0] a, d, input int einf);
        add(0, 1, 1, a, d, 0, -1, einf);
    endtask

    task automatic rd_(input logic [15:0] a, input bit edv, input int edo, einf);
        add(0, 1, 0, a, 16'h0, edv, edo, einf);
    endtask

    task automatic idle(input bit edv, input int edo, einf);
        add(0, 0, 0, 16'h0, 16'h0, edv, edo, einf);
    endtask

    task automatic chk(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s row=%0d got=%0h exp=%0h", name, k, act, exp);
        end
    endtask

    task automatic run(input bit sel);
        logic        dv;
        logic [15:0] dout;
        logic [3:0]  inf;
        foreach (tbl[k]) begin
            @(posedge clk);
            #1;
            rst = tbl[k].r;
            if (sel) begin
                if1.enable = tbl[k].e; if1.wr = tbl[k].w; if1.addr = tbl[k].a; if1.data_in = tbl[k].d;
                dv = if1.data_valid; dout = if1.data_out; inf = if1.inflight;
            end else begin
                if0.enable = tbl[k].e; if0.wr = tbl[k].w; if0.addr = tbl[k].a; if0.data_in = tbl[k].d;
                dv = if0.data_valid; dout = if0.data_out; inf = if0.inflight;
            end
            chk(sel ? "l1_data_valid" : "data_valid", k, int'(dv), int'(tbl[k].edv));
            if (tbl[k].edo >= 0)
                chk(sel ? "l1_data_out" : "data_out", k, int'(dout), tbl[k].edo);
            if (tbl[k].einf >= 0)
                chk(sel ? "l1_inflight" : "inflight", k, int'(inf), tbl[k].einf);
        end
    endtask

    initial begin
        if0.enable = 0; if0.wr = 0; if0.addr = 0; if0.data_in = 0;
        if1.enable = 0; if1.wr = 0; if1.addr = 0; if1.data_in = 0;
        rst = 1;
        repeat (2) @(posedge clk);

        // reset state
        add(1, 0, 0, 16'h0, 16'h0, 0, 0, 0);
        // write then read
        wr_(16'h0010, 16'hBEEF, 0);
        rd_(16'h0010, 0, -1, 0);
        idle(0, -1, 1); idle(0, -1, 1); idle(0, -1, 1);
        idle(1, 16'hBEEF, 1);
        idle(0, -1, 0);
        // cache fill burst
        for (int i = 0; i < 8; i++) wr_(16'(16'h0100 + 2*i), 16'(16'hA000 + i), 0);
        for (int i = 0; i < 8; i++) rd_(16'(16'h0100 + 2*i), i >= 4, i >= 4 ? 16'hA000 + i - 4 : -1, i < 4 ? i : 4);
        for (int i = 8; i < 13; i++) idle(i < 12, i < 12 ? 16'hA000 + i - 4 : -1, 12 - i);
        // in-flight write isolation
        wr_(16'h0020, 16'h1111, 0);
        rd_(16'h0020, 0, -1, 0);
        wr_(16'h0020, 16'h2222, 1);
        rd_(16'h0020, 0, -1, 1);
        idle(0, -1, 2);
        idle(1, 16'h1111, 2);
        idle(0, -1, 1);
        idle(1, 16'h2222, 1);
        idle(0, -1, 0);
        // reset mid-burst; the write presented during reset must be ignored
        wr_(16'h0030, 16'h3333, 0);
        rd_(16'h0030, 0, -1, 0);
        rd_(16'h0030, 0, -1, 1);
        rd_(16'h0030, 0, -1, 2);
        add(1, 1, 1, 16'h0030, 16'hDEAD, 0, -1, 3);
        rd_(16'h0030, 0, -1, 0);
        idle(0, -1, 1); idle(0, -1, 1); idle(0, -1, 1);
        idle(1, 16'h3333, 1);
        idle(0, -1, 0);
        // address bit 0 ignored, bubbles between reads
        wr_(16'h0002, 16'h5A5A, 0);
        rd_(16'h0003, 0, -1, 0);
        idle(0, -1, 1);
        rd_(16'h0002, 0, -1, 1);
        idle(0, -1, 2);
        idle(1, 16'h5A5A, 2);
        idle(0, -1, 1);
        idle(1, 16'h5A5A, 1);
        idle(0, -1, 0);
        run(0);

        // LATENCY=1 build
        tbl.delete();
        wr_(16'h0040, 16'h4444, 0);
        wr_(16'h0042, 16'h4545, 0);
        rd_(16'h0040, 0, -1, 0);
        rd_(16'h0042, 1, 16'h4444, 1);
        idle(1, 16'h4545, 1);
        idle(0, -1, 0);
        run(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
